// File: rtl/sema_arbiter.sv
// Round-robin arbiter for a single-bit semaphore held in an external synchronous RS
// flip-flop; every set/clear is confirmed through the flip-flop output before moving on.
module sema_arbiter #(
   parameter int N_REQ   = 4,
   parameter int ID_W    = 2,
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 200
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] rel,
   input  logic             sema_state,
   output logic             sema_set,
   output logic             sema_reset,
   output logic [N_REQ-1:0] gnt,
   output logic [ID_W-1:0]  owner_id,
   output logic             busy,
   output logic             timeout_evt
);

   localparam logic [2:0] S_INIT = 3'd0;
   localparam logic [2:0] S_IDLE = 3'd1;
   localparam logic [2:0] S_SET  = 3'd2;
   localparam logic [2:0] S_HELD = 3'd3;
   localparam logic [2:0] S_CLR  = 3'd4;

   logic [2:0]       state_q, state_d;
   logic             set_q, set_d;
   logic             clr_q, clr_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [ID_W-1:0]  owner_q, owner_d;
   logic             busy_q, busy_d;
   logic             tevt_q, tevt_d;
   logic [ID_W-1:0]  rr_q, rr_d;
   logic [CNT_W-1:0] wd_q, wd_d;

   logic [ID_W-1:0]  sel_id;
   logic [ID_W:0]    cand;
   logic             wd_hit;
   logic [ID_W-1:0]  rr_wrap;

   assign wd_hit  = (TIMEOUT != 0) && (wd_q == CNT_W'(TIMEOUT - 1));
   assign rr_wrap = (owner_q == ID_W'(N_REQ - 1)) ? '0 : owner_q + ID_W'(1);

   // Scan offsets from the far end down so the nearest requester at or after rr_q wins.
   always_comb begin
      sel_id = rr_q;
      cand   = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         cand = {1'b0, rr_q} + (ID_W + 1)'(k);
         if (cand >= (ID_W + 1)'(N_REQ)) cand = cand - (ID_W + 1)'(N_REQ);
         if (req[cand[ID_W-1:0]]) sel_id = cand[ID_W-1:0];
      end
   end

   always_comb begin
      state_d = state_q;
      set_d   = set_q;
      clr_d   = clr_q;
      gnt_d   = '0;
      owner_d = owner_q;
      busy_d  = busy_q;
      tevt_d  = 1'b0;
      rr_d    = rr_q;
      wd_d    = wd_q;
      case (state_q)
         S_INIT: begin
            set_d  = 1'b0;
            busy_d = 1'b0;
            clr_d  = sema_state;
            if (!sema_state) state_d = S_IDLE;
         end
         S_IDLE: begin
            // A set semaphore with no owner means the flip-flop was disturbed externally.
            if (sema_state) begin
               state_d = S_INIT;
            end else if (|req) begin
               owner_d = sel_id;
               set_d   = 1'b1;
               busy_d  = 1'b1;
               state_d = S_SET;
            end
         end
         S_SET: begin
            if (sema_state) begin
               set_d   = 1'b0;
               gnt_d   = N_REQ'(1) << owner_q;
               wd_d    = '0;
               state_d = S_HELD;
            end
         end
         S_HELD: begin
            if (rel[owner_q]) begin
               clr_d   = 1'b1;
               state_d = S_CLR;
            end else if (wd_hit) begin
               tevt_d  = 1'b1;
               clr_d   = 1'b1;
               state_d = S_CLR;
            end else if (wd_q != '1) begin
               wd_d = wd_q + CNT_W'(1);
            end
         end
         S_CLR: begin
            if (!sema_state) begin
               clr_d   = 1'b0;
               busy_d  = 1'b0;
               rr_d    = rr_wrap;
               state_d = S_IDLE;
            end
         end
         default: begin
            set_d   = 1'b0;
            clr_d   = 1'b0;
            busy_d  = 1'b0;
            state_d = S_INIT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_INIT;
         set_q   <= 1'b0;
         clr_q   <= 1'b0;
         gnt_q   <= '0;
         owner_q <= '0;
         busy_q  <= 1'b0;
         tevt_q  <= 1'b0;
         rr_q    <= '0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         set_q   <= set_d;
         clr_q   <= clr_d;
         gnt_q   <= gnt_d;
         owner_q <= owner_d;
         busy_q  <= busy_d;
         tevt_q  <= tevt_d;
         rr_q    <= rr_d;
         wd_q    <= wd_d;
      end
   end

   assign sema_set    = set_q;
   assign sema_reset  = clr_q;
   assign gnt         = gnt_q;
   assign owner_id    = owner_q;
   assign busy        = busy_q;
   assign timeout_evt = tevt_q;

endmodule

// File: tb/tb_sema_arbiter.sv
// Bench for sema_arbiter: an RS flip-flop plant, a per-cycle protocol reference model,
// directed scenarios and a randomized requester population.
module tb_sema_arbiter;

   localparam int N     = 4;
   localparam int IDW   = 2;
   localparam int CW    = 8;
   localparam int TMO   = 10;
   localparam int HMAX  = (1 << CW) - 1;

   localparam logic [2:0] PH_INIT = 3'd0;
   localparam logic [2:0] PH_IDLE = 3'd1;
   localparam logic [2:0] PH_SET  = 3'd2;
   localparam logic [2:0] PH_HELD = 3'd3;
   localparam logic [2:0] PH_CLR  = 3'd4;

   typedef struct packed {
      logic [2:0]     ph;
      logic           set;
      logic           rst;
      logic [N-1:0]   gnt;
      logic [IDW-1:0] own;
      logic           busy;
      logic           tevt;
      logic [IDW-1:0] rr;
      int             hold;
   } mdl_t;

   logic           clk = 1'b0;
   logic           reset_n = 1'b0;
   logic [N-1:0]   req = '0;
   logic [N-1:0]   rel = '0;
   logic           sema_q = 1'b0;
   logic           sema_set, sema_reset, busy, timeout_evt;
   logic [N-1:0]   gnt;
   logic [IDW-1:0] owner_id;
   logic           ff_load = 1'b0;
   logic           ff_val = 1'b0;
   mdl_t           m = '0;

   int checks = 0;
   int errors = 0;

   sema_arbiter #(.N_REQ(N), .ID_W(IDW), .CNT_W(CW), .TIMEOUT(TMO)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req        (req),
      .rel        (rel),
      .sema_state (sema_q),
      .sema_set   (sema_set),
      .sema_reset (sema_reset),
      .gnt        (gnt),
      .owner_id   (owner_id),
      .busy       (busy),
      .timeout_evt(timeout_evt)
   );

   always #5 clk = ~clk;

   // RS flip-flop plant; ff_load lets the bench corrupt or preload it.
   always @(posedge clk) begin
      if (ff_load)         sema_q <= ff_val;
      else if (sema_set)   sema_q <= 1'b1;
      else if (sema_reset) sema_q <= 1'b0;
   end

   function automatic mdl_t mdl_next(input mdl_t c, input logic [N-1:0] rq,
                                     input logic [N-1:0] rl, input logic s);
      mdl_t n;
      bit   found;
      n = c;
      n.gnt  = '0;
      n.tevt = 1'b0;
      found  = 1'b0;
      case (c.ph)
         PH_INIT: begin
            n.rst = s;
            if (!s) n.ph = PH_IDLE;
         end
         PH_IDLE: begin
            if (s) n.ph = PH_INIT;
            else if (rq != '0) begin
               for (int k = 0; k < N; k++) begin
                  int idx;
                  idx = (int'(c.rr) + k) % N;
                  if (!found && rq[idx]) begin
                     n.own = IDW'(idx);
                     found = 1'b1;
                  end
               end
               n.set  = 1'b1;
               n.busy = 1'b1;
               n.ph   = PH_SET;
            end
         end
         PH_SET: if (s) begin
            n.set  = 1'b0;
            n.gnt  = N'(1) << c.own;
            n.hold = 0;
            n.ph   = PH_HELD;
         end
         PH_HELD: begin
            if (rl[c.own]) begin
               n.rst = 1'b1;
               n.ph  = PH_CLR;
            end else if (TMO != 0 && c.hold == TMO - 1) begin
               n.tevt = 1'b1;
               n.rst  = 1'b1;
               n.ph   = PH_CLR;
            end else if (c.hold < HMAX) begin
               n.hold = c.hold + 1;
            end
         end
         PH_CLR: if (!s) begin
            n.rst  = 1'b0;
            n.busy = 1'b0;
            n.rr   = IDW'((int'(c.own) + 1) % N);
            n.ph   = PH_IDLE;
         end
         default: n.ph = PH_INIT;
      endcase
      return n;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) m <= '0;
      else          m <= mdl_next(m, req, rel, sema_q);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("cyc_set",   32'(sema_set),    32'(m.set));
      chk("cyc_reset", 32'(sema_reset),  32'(m.rst));
      chk("cyc_gnt",   32'(gnt),         32'(m.gnt));
      chk("cyc_owner", 32'(owner_id),    32'(m.own));
      chk("cyc_busy",  32'(busy),        32'(m.busy));
      chk("cyc_tevt",  32'(timeout_evt), 32'(m.tevt));
      chk("set_reset_excl", 32'(sema_set & sema_reset), 32'd0);
      chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_gnt(input string tag);
      int n;
      n = 0;
      while (gnt == '0 && n < 40) begin
         tick(1);
         n++;
      end
      if (gnt == '0) chk(tag, 32'd0, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL sim_bound: time limit reached, errors=%0d", errors);
      $fatal(1, "time bound exceeded");
   end

   initial begin
      logic [N-1:0] rr_exp [5];
      logic [N-1:0] g;
      int           n, rst_cnt, holder, hold_left;
      bit           cleared;
      rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
      rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

      // Reset with the flip-flop preloaded high
      ff_load = 1'b1;
      ff_val  = 1'b1;
      tick(3);
      chk("rst_set",   32'(sema_set),    32'd0);
      chk("rst_reset", 32'(sema_reset),  32'd0);
      chk("rst_gnt",   32'(gnt),         32'd0);
      chk("rst_owner", 32'(owner_id),    32'd0);
      chk("rst_busy",  32'(busy),        32'd0);
      chk("rst_tevt",  32'(timeout_evt), 32'd0);
      ff_load = 1'b0;
      reset_n = 1'b1;
      tick(1);
      rst_cnt = 0;
      n = 0;
      while (sema_reset && n < 50) begin
         rst_cnt++;
         n++;
         tick(1);
      end
      chk("init_rst_cycles", 32'(rst_cnt), 32'd2);
      chk("init_ff_cleared", 32'(sema_q), 32'd0);

      // Single request from requester 1
      req = 4'b0010;
      tick(1);
      chk("t2_set_e0", 32'(sema_set), 32'd1);
      tick(1);
      chk("t2_set_e1", 32'(sema_set), 32'd1);
      chk("t2_gnt_e1", 32'(gnt), 32'd0);
      tick(1);
      chk("t2_set_e2", 32'(sema_set), 32'd0);
      chk("t2_gnt_e2", 32'(gnt), 32'b0010);
      chk("t2_owner",  32'(owner_id), 32'd1);
      chk("t2_busy",   32'(busy), 32'd1);
      req = '0;
      rel = 4'b0010;
      tick(1);
      rel = '0;
      chk("t2_gnt_pulse", 32'(gnt), 32'd0);
      chk("t2_clr_r0", 32'(sema_reset), 32'd1);
      tick(1);
      chk("t2_clr_r1", 32'(sema_reset), 32'd1);
      tick(1);
      chk("t2_clr_r2", 32'(sema_reset), 32'd0);
      chk("t2_busy_end", 32'(busy), 32'd0);

      // Fresh reset, then all four requesting: round-robin order from 0
      #2 reset_n = 1'b0;
      tick(2);
      reset_n = 1'b1;
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         wait_gnt("t3_gnt_timeout");
         chk("t3_rr_seq", 32'(gnt), 32'(rr_exp[i]));
         g = gnt;
         tick(3);
         rel = g;
         tick(1);
         rel = '0;
      end
      req = '0;
      tick(4);

      // Non-owner release is ignored
      req = 4'b0100;
      wait_gnt("t4_gnt_timeout");
      chk("t4_gnt", 32'(gnt), 32'b0100);
      req = '0;
      tick(2);
      rel = 4'b0001;
      tick(1);
      rel = '0;
      chk("t4_ignore_rst", 32'(sema_reset), 32'd0);
      chk("t4_ignore_busy", 32'(busy), 32'd1);
      tick(2);
      chk("t4_ignore_rst2", 32'(sema_reset), 32'd0);
      rel = 4'b0100;
      tick(1);
      rel = '0;
      chk("t4_own_rel", 32'(sema_reset), 32'd1);
      tick(3);
      chk("t4_busy_end", 32'(busy), 32'd0);

      // Owner never releases: watchdog
      req = 4'b1010;
      wait_gnt("t5_gnt_timeout");
      chk("t5_gnt_first", 32'(gnt), 32'b1000);
      req = 4'b0010;
      n = 0;
      while (!timeout_evt && n < 40) begin
         tick(1);
         n++;
      end
      chk("t5_timeout_delay", 32'(n), 32'(TMO));
      tick(1);
      chk("t5_tevt_pulse", 32'(timeout_evt), 32'd0);
      wait_gnt("t5_gnt2_timeout");
      chk("t5_next_gnt", 32'(gnt), 32'b0010);
      req = '0;
      tick(1);
      rel = 4'b0010;
      tick(1);
      rel = '0;
      tick(3);

      // Reset during HELD with the semaphore set
      req = 4'b0001;
      wait_gnt("t6_gnt_timeout");
      chk("t6_gnt", 32'(gnt), 32'b0001);
      req = '0;
      tick(2);
      #2 reset_n = 1'b0;
      #1;
      chk("t6_rst_set",   32'(sema_set),    32'd0);
      chk("t6_rst_reset", 32'(sema_reset),  32'd0);
      chk("t6_rst_gnt",   32'(gnt),         32'd0);
      chk("t6_rst_owner", 32'(owner_id),    32'd0);
      chk("t6_rst_busy",  32'(busy),        32'd0);
      chk("t6_rst_tevt",  32'(timeout_evt), 32'd0);
      chk("t6_ff_still_set", 32'(sema_q), 32'd1);
      tick(2);
      reset_n = 1'b1;
      req = 4'b0100;
      tick(1);
      chk("t6_init_rst", 32'(sema_reset), 32'd1);
      chk("t6_init_nognt", 32'(gnt), 32'd0);
      cleared = 1'b0;
      n = 0;
      while (gnt == '0 && n < 40) begin
         if (!sema_q) cleared = 1'b1;
         tick(1);
         n++;
      end
      chk("t6_cleared_first", 32'(cleared), 32'd1);
      chk("t6_gnt_after", 32'(gnt), 32'b0100);
      req = '0;
      rel = 4'b0100;
      tick(1);
      rel = '0;
      tick(4);

      // Randomized requesters, releases, noise and flip-flop disturbances
      holder = -1;
      hold_left = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rel = '0;
         ff_load = 1'b0;
         if (gnt != '0) begin
            for (int i = 0; i < N; i++) begin
               if (gnt[i]) begin
                  holder = i;
                  req[i] = 1'b0;
               end
            end
            hold_left = $urandom_range(0, 15);
         end else if (holder >= 0) begin
            if (!busy) holder = -1;
            else if (hold_left == 0) begin
               rel[holder] = 1'b1;
               holder = -1;
            end else if (hold_left < 15) hold_left--;
         end
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 5) == 0) req[i] = 1'b1;
         if ($urandom_range(0, 3) == 0) rel = rel | N'($urandom());
         if ($urandom_range(0, 199) == 0) begin
            ff_load = 1'b1;
            ff_val  = 1'($urandom_range(0, 1));
         end
      end
      req = '0;
      rel = '0;
      ff_load = 1'b0;
      tick(30);
      chk("end_idle_busy", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sema_arbiter.md
Name: sema_arbiter

Overview:
- Upstream control stage for the synchronous RS flip-flop that holds the bit semaphore.
- Arbitrates N requesters round-robin and drives the flip-flop's set/reset inputs.
- Uses the flip-flop's `out` as confirmation before granting or freeing.
- Provides owner tracking, release checking and a hold watchdog.

Parameters:
- N_REQ, 4: number of requesters.
- ID_W, 2: owner index width; must satisfy 2^ID_W >= N_REQ.
- CNT_W, 8: watchdog counter width.
- TIMEOUT, 200: maximum cycles in HELD before forced release. 0 disables the watchdog. Must be < 2^CNT_W.

Ports:
- clk, in, 1: rising-edge clock.
- reset_n, in, 1: asynchronous active-low reset.
- req, in, N_REQ: level request per requester; held until its gnt bit pulses.
- rel, in, N_REQ: release pulse per requester.
- sema_state, in, 1: semaphore bit from the RS flip-flop `out`.
- sema_set, out, 1: drives the flip-flop `set`.
- sema_reset, out, 1: drives the flip-flop `reset`.
- gnt, out, N_REQ: one-hot, one-cycle grant pulse.
- owner_id, out, ID_W: index of the current/last owner.
- busy, out, 1: high in SET, HELD and CLR.
- timeout_evt, out, 1: one-cycle pulse on watchdog release.

Behaviour:
- All outputs are registered. Async reset gives:
  - state=INIT; sema_set=0, sema_reset=0, gnt=0, owner_id=0, busy=0, timeout_evt=0.
  - rr pointer=0, watchdog=0.
- Reset asserted mid-operation aborts immediately to these values; no grant or event pulse is emitted.
- **INIT** (first state after reset release):
  - sema_reset=1 until sema_state==0 is sampled, then go IDLE with sema_reset=0.
  - This clears any stale flip-flop value.
- **IDLE**:
  - With sema_state==0 and req!=0, select the first set req bit searching upward from the rr pointer, wrapping at N_REQ-1 to 0.
  - Load owner_id, set sema_set=1, busy=1, go SET.
  - If sema_state==1 in IDLE (external corruption), go INIT.
- **SET**:
  - Hold sema_set=1 until sema_state==1 is sampled.
  - Then: sema_set=0, gnt[owner_id]=1 for exactly one cycle, watchdog=0, go HELD.
  - The grant completes even if req drops meanwhile.
  - Latency: req sampled at edge E gives sema_set high after E, flip-flop set at E+1, gnt high after E+2.
- **HELD**:
  - rel[owner_id]=1: sema_reset=1, go CLR. rel bits of non-owners are ignored.
  - Otherwise the watchdog increments each cycle. If TIMEOUT!=0 and the watchdog reaches TIMEOUT-1 without release: timeout_evt=1 for one cycle, sema_reset=1, go CLR.
  - rel on the same edge as the timeout takes precedence; no timeout_evt.
  - New requests are not queued; requesters keep req high.
- **CLR**:
  - Hold sema_reset=1 until sema_state==0 is sampled.
  - Then: sema_reset=0, busy=0, rr pointer=owner_id+1 (wrapping N_REQ-1 to 0), go IDLE.
  - owner_id keeps its last value.
- sema_set and sema_reset are never high in the same cycle.
- gnt is never multi-hot.
- Watchdog saturates and never wraps.

Test Plan:
- Flip-flop out=1 before reset, reset_n released: sema_reset=1 until sema_state falls, then IDLE; no gnt.
- req=4'b0010 from IDLE at edge E: sema_set high E..E+2, gnt=4'b0010 for one cycle after E+2, owner_id=1, busy=1; rel[1] pulse leads to sema_reset for 2 cycles, then busy=0.
- req=4'b1111 held, each owner releases 3 cycles after its grant: gnt sequence 0001, 0010, 0100, 1000, 0001.
- Owner 2 holding, rel=4'b0001 pulsed: no sema_reset, state stays HELD; then rel=4'b0100 releases.
- TIMEOUT=10, owner never releases: timeout_evt pulses once 10 cycles after the gnt cycle, the semaphore clears, and the next requester is granted.
- reset_n low during HELD with sema_state=1: outputs immediately zero; after release, INIT clears the flip-flop before any new gnt.
